// File: rtl/key_stream_loader_if.sv
// Handshake and key bus between the key stream loader, the NVM reader and the locked core.
// Master is the controller/NVM side; slave is the loader itself.
interface key_stream_loader_if #(
    parameter int unsigned KEY_WIDTH = 16
);
    logic                 start;
    logic                 zeroize;
    logic                 nvm_req;
    logic                 nvm_bit;
    logic                 nvm_bit_valid;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 core_enable;
    logic                 busy;
    logic                 error;
    logic                 lockout;

    modport master (
        output start, zeroize, nvm_bit, nvm_bit_valid,
        input  nvm_req, key_out, key_valid, core_enable, busy, error, lockout
    );

    modport slave (
        input  start, zeroize, nvm_bit, nvm_bit_valid,
        output nvm_req, key_out, key_valid, core_enable, busy, error, lockout
    );
endinterface

// File: rtl/key_stream_loader.sv
// Loads a serial key plus XOR checksum from NVM, verifies it and presents it in parallel;
// gates the locked core until a verified key is present and locks out after repeated failures.
module key_stream_loader #(
    parameter int unsigned KEY_WIDTH = 16,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic                 clk,
    input logic                 rst,
    key_stream_loader_if.slave  bus
);
    localparam int unsigned StreamLen = KEY_WIDTH + 8;
    localparam int unsigned CntW      = $clog2(StreamLen + 1);
    localparam int unsigned ToW       = $clog2(TIMEOUT + 1);
    localparam int unsigned RetryW    = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StReady, StLockout} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ToW-1:0]         to_cnt_q, to_cnt_d;
    logic [StreamLen-1:0]   shadow_q, shadow_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic                   key_valid_q, key_valid_d;
    logic                   error_q, error_d;
    logic [RetryW-1:0]      retry_q, retry_d;
    logic                   timeout_q, timeout_d;
    logic [7:0]             calc_sum;

    always_comb begin
        calc_sum = '0;
        for (int k = 0; k < int'(KEY_WIDTH / 8); k++) begin
            calc_sum = calc_sum ^ shadow_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        to_cnt_d    = to_cnt_q;
        shadow_d    = shadow_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        error_d     = error_q;
        retry_d     = retry_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle, StReady: begin
                if (bus.start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    shadow_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            StLoad: begin
                if (bus.nvm_bit_valid) begin
                    shadow_d[bit_cnt_q] = bus.nvm_bit;
                    bit_cnt_d           = bit_cnt_q + 1'b1;
                    to_cnt_d            = '0;
                    if (bit_cnt_q == CntW'(StreamLen - 1)) begin
                        state_d = StCheck;
                    end
                end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
                    state_d   = StCheck;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (!timeout_q && (calc_sum == shadow_q[StreamLen-1 -: 8])) begin
                    state_d     = StReady;
                    key_d       = shadow_q[KEY_WIDTH-1:0];
                    key_valid_d = 1'b1;
                    error_d     = 1'b0;
                    retry_d     = '0;
                end else begin
                    // A failed reload also drops any previously verified key.
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    error_d     = 1'b1;
                    retry_d     = retry_q + 1'b1;
                    if (retry_q >= RetryW'(MAX_RETRY)) begin
                        state_d = StLockout;
                    end else begin
                        state_d   = StLoad;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                        shadow_d  = '0;
                        timeout_d = 1'b0;
                    end
                end
            end
            StLockout: begin
                key_d       = '0;
                key_valid_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // zeroize wins over start and over a same-cycle check result; lockout is immune.
        if (bus.zeroize && (state_q != StLockout)) begin
            state_d     = StIdle;
            key_d       = '0;
            key_valid_d = 1'b0;
            error_d     = 1'b0;
            retry_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            shadow_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            error_q     <= 1'b0;
            retry_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            to_cnt_q    <= to_cnt_d;
            shadow_q    <= shadow_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            error_q     <= error_d;
            retry_q     <= retry_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.nvm_req     = (state_q == StLoad);
    assign bus.busy        = (state_q == StLoad) || (state_q == StCheck);
    assign bus.lockout     = (state_q == StLockout);
    assign bus.key_out     = key_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.core_enable = key_valid_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_key_stream_loader.sv
// Bench for key_stream_loader: directed streams, expected check results queued per attempt and
// compared by a monitor one cycle after each CHECK state.
module tb_key_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    key_stream_loader_if #(.KEY_WIDTH(16)) bus ();

    key_stream_loader #(
        .KEY_WIDTH(16),
        .MAX_RETRY(2),
        .TIMEOUT  (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [15:0] key;
        logic        kv;
        logic        err;
        logic        lk;
        logic        req;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [23:0] GoodA5 = {8'h66, 16'hA5C3};
    localparam logic [23:0] BadA5  = {8'h67, 16'hA5C3};
    localparam logic [23:0] Good12 = {8'h26, 16'h1234};
    localparam logic [23:0] Bad12  = {8'h27, 16'h1234};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] key, input logic kv, input logic err, input logic lk,
                        input logic req);
        exp_t e;
        e.key = key; e.kv = kv; e.err = err; e.lk = lk; e.req = req;
        sb_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.nvm_bit_valid = 1'b0;
        bus.start         = 1'b0;
    endtask

    // Presents bits s[from..to-1]; a bit counts as taken when valid is driven while nvm_req is high.
    task automatic send_bits(input logic [23:0] s, input int from, input int to, input bit rnd,
                             input bit pulse, output int ncyc);
        int idx;
        idx  = from;
        ncyc = 0;
        while (idx < to && ncyc < 2000) begin
            @(negedge clk);
            ncyc++;
            bus.start   = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.nvm_bit = s[idx];
            if (bus.nvm_req) begin
                bus.nvm_bit_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.nvm_bit_valid) idx++;
            end else begin
                bus.nvm_bit_valid = 1'b0;
            end
        end
        chk("stream_accepted", idx, to);
    endtask

    task automatic send_full(input logic [23:0] s);
        int n;
        send_bits(s, 0, 24, 1'b0, 1'b0, n);
        idle();
    endtask

    // Monitor: the cycle after CHECK the result must match the oldest queued expectation.
    initial begin
        bit   pending;
        exp_t e;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_key_out", bus.key_out, e.key);
                    chk("sb_key_valid", bus.key_valid, e.kv);
                    chk("sb_core_enable", bus.core_enable, e.kv);
                    chk("sb_error", bus.error, e.err);
                    chk("sb_lockout", bus.lockout, e.lk);
                    chk("sb_nvm_req", bus.nvm_req, e.req);
                end
            end
            if (!rst && bus.busy && !bus.nvm_req) pending = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bus.start = 1'b0;
        bus.zeroize = 1'b0;
        bus.nvm_bit = 1'b0;
        bus.nvm_bit_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_key_out", bus.key_out, 16'h0);
        chk("rst_key_valid", bus.key_valid, 0);
        chk("rst_core_enable", bus.core_enable, 0);
        chk("rst_nvm_req", bus.nvm_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_lockout", bus.lockout, 0);
        rst = 1'b0;

        // Good key back-to-back: valid in the 27th cycle counting the start cycle as the first
        push(16'hA5C3, 1, 0, 0, 0);
        do_start();
        send_bits(GoodA5, 0, 24, 1'b0, 1'b0, n);
        chk("b2b_cycles", n, 24);
        idle();
        chk("latency_kv_low_cyc26", bus.key_valid, 0);
        chk("latency_busy_check", bus.busy, 1);
        @(negedge clk);
        chk("latency_kv_high_cyc27", bus.key_valid, 1);
        chk("latency_key", bus.key_out, 16'hA5C3);
        chk("ready_busy", bus.busy, 0);

        // Bad checksum then automatic reload with the right stream
        do_start();
        push(16'h0, 0, 1, 0, 1);
        send_full(BadA5);
        push(16'hA5C3, 1, 0, 0, 0);
        send_full(GoodA5);

        // Three failures in a row (retry counter was cleared by the success) -> lockout
        do_start();
        push(16'h0, 0, 1, 0, 1);
        send_full(BadA5);
        push(16'h0, 0, 1, 0, 1);
        send_full(BadA5);
        push(16'h0, 0, 1, 1, 0);
        send_full(BadA5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.zeroize = 1'b1;
        repeat (5) @(negedge clk);
        chk("lock_sticky", bus.lockout, 1);
        chk("lock_nvm_req", bus.nvm_req, 0);
        chk("lock_busy", bus.busy, 0);
        chk("lock_key_out", bus.key_out, 16'h0);
        bus.start = 1'b0;
        bus.zeroize = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_clears_lockout", bus.lockout, 0);
        chk("rst_clears_error", bus.error, 0);

        // Valid in IDLE is ignored; then a timeout after 10 bits
        repeat (3) begin
            @(negedge clk);
            bus.nvm_bit_valid = 1'b1;
            bus.nvm_bit = 1'b1;
        end
        chk("idle_ignores_valid", bus.busy, 0);
        push(16'h0, 0, 1, 0, 1);
        do_start();
        send_bits(24'hFFFFFF, 0, 10, 1'b0, 1'b0, n);
        idle();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.busy && !bus.nvm_req) && k < 200);
        chk("timeout_cycles", k, 64);
        push(16'h1234, 1, 0, 0, 0);
        send_full(Good12);

        // Reload from READY with a bad checksum: old key held during LOAD
        push(16'h0, 0, 1, 0, 1);
        do_start();
        send_bits(Bad12, 0, 12, 1'b0, 1'b0, n);
        idle();
        chk("reload_kv_held", bus.key_valid, 1);
        chk("reload_key_held", bus.key_out, 16'h1234);
        chk("reload_busy", bus.busy, 1);
        send_bits(Bad12, 12, 24, 1'b0, 1'b0, n);
        idle();

        // zeroize mid-LOAD of the automatic reload
        send_bits(Good12, 0, 5, 1'b0, 1'b0, n);
        idle();
        @(negedge clk);
        bus.zeroize = 1'b1;
        @(negedge clk);
        bus.zeroize = 1'b0;
        chk("zero_busy", bus.busy, 0);
        chk("zero_nvm_req", bus.nvm_req, 0);
        chk("zero_key_out", bus.key_out, 16'h0);
        chk("zero_key_valid", bus.key_valid, 0);
        chk("zero_error", bus.error, 0);

        // Random 50% valid with start pulses while busy
        push(16'hA5C3, 1, 0, 0, 0);
        do_start();
        send_bits(GoodA5, 0, 24, 1'b1, 1'b1, n);
        idle();
        repeat (3) @(negedge clk);
        chk("rand_key_out", bus.key_out, 16'hA5C3);
        chk("rand_busy", bus.busy, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
